tmr_recovery_sequencer: RTL and testbench
=========================================

# tmr_recovery_sequencer

Sequencing controller for the triple-modular-redundant RISC-V core. It watches the voter's per-core disagreement flags and keeps a checkpoint PC from the last fully agreed cycle. On a single-core fault it runs a fixed recovery sequence: hold all cores, reset the faulty core, replay from the checkpoint with stores redirected to the recovery register, verify agreement, then resume. It sits between the voter and the PC controller, reset controller, and recovery-register/data-memory steering.

## Interface
Parameters:
- HOLD_CYCLES, 2: cycles spent in HOLD before the faulty-core reset.
- RST_CYCLES, 2: cycles the faulty core's reset is asserted.
- REPLAY_CYCLES, 4: cycles of replay that must all show full agreement.
- MAX_RETRY, 3: failed replays tolerated before FATAL.
- CNT_W, 8: width of fault_count.

Ports:
- clk  in  1  system clock, rising edge.
- rst_in  in  1  asynchronous, active-low reset.
- voter_state  in  3  bit i = core i (A=0, B=1, C=2) disagrees with majority; 3'b000 = all agree.
- pc_voted  in  32  voted PC for the current cycle.
- core_hold  out  1  stall all three cores.
- core_rst_n  out  3  per-core active-low reset, bit i = core i.
- pc_override_en  out  1  PC controller loads pc_override.
- pc_override  out  32  checkpoint PC.
- recovery_mode  out  1  high from HOLD through RESUME.
- wr_sel  out  1  0 = stores to data memory, 1 = stores to recovery register.
- rd_sel  out  1  0 = loads from data memory, 1 = loads from recovery register.
- faulty_core  out  2  index of the core under recovery (0..2).
- fault_count  out  CNT_W  successful recoveries, saturating.
- fatal  out  1  sticky unrecoverable fault.
- busy  out  1  state is not NORMAL.

## Operation
- States: NORMAL, HOLD, RESET, REPLAY, RESUME, FATAL.
- One down-counter `cnt` times each timed state. It loads on every state entry.

NORMAL:
- When voter_state == 0, capture ckpt_pc <= pc_voted.
- When voter_state is one-hot, latch faulty_core = bit index, retry = 0, and go to HOLD.
- When two or more bits are set, go to FATAL.
- When voter_state is non-zero, ckpt_pc does not update in that cycle.

HOLD:
- core_hold = 1.
- After HOLD_CYCLES, go to RESET.
- voter_state is ignored.

RESET:
- core_hold = 1, core_rst_n[faulty_core] = 0, other bits 1.
- After RST_CYCLES, go to REPLAY.
- voter_state is ignored.

REPLAY:
- core_hold = 0.
- pc_override_en = 1 on the first replay cycle only.
- pc_override = ckpt_pc.
- wr_sel = rd_sel = 1.
- If voter_state != 0 in any replay cycle:
  - when retry == MAX_RETRY-1, go to FATAL;
  - otherwise retry++ and go to HOLD, keeping the originally latched faulty_core.
- If all REPLAY_CYCLES cycles are clean, go to RESUME.

RESUME:
- One cycle. wr_sel = rd_sel = 0, core_hold = 0.
- fault_count++ (saturates at 2^CNT_W-1).
- Next state is NORMAL. ckpt_pc resumes capturing in NORMAL.

FATAL:
- core_hold = 1, core_rst_n = 3'b111, fatal = 1.
- Left only by rst_in.

Output rules:
- recovery_mode = 1 in HOLD, RESET, REPLAY and RESUME.
- busy = 1 in every state except NORMAL.

## Timing
- Reset values:
  - state = NORMAL, ckpt_pc = 0, cnt = 0, retry = 0;
  - core_hold = 0, core_rst_n = 3'b111, pc_override_en = 0, pc_override = 0;
  - recovery_mode = 0, wr_sel = 0, rd_sel = 0;
  - faulty_core = 0, fault_count = 0, fatal = 0, busy = 0.
- Asserting rst_in mid-sequence returns to NORMAL immediately, without waiting for a clock edge.
- Outputs are Moore-decoded from registered state, pc_override, faulty_core and the counters. There is no combinational input-to-output path.
- Latency: a mismatch sampled at edge N puts the block in HOLD after edge N, so core_hold is high in cycle N+1.
- Clean recovery occupies HOLD_CYCLES + RST_CYCLES + REPLAY_CYCLES + 1 cycles (9 with defaults). The block is back in NORMAL in cycle N+10.
- A replay failure sampled at an edge enters HOLD (or FATAL) at that edge. The remaining replay cycles are abandoned.
- If a mismatch coincides with the RESUME cycle, it is not acted on until NORMAL samples it on the next edge.

## Structure
- Shared package `tmr_pkg`:
  - state enum;
  - core index constants CORE_A/B/C = 0/1/2;
  - VOTE_AGREE = 3'b000;
  - function `onehot3` (single-fault detect).
- No sub-modules. Counters and the FSM live in this block.

## Test plan
- Single fault: after reset, voter_state = 0 with pc_voted = 0x40, then voter_state = 3'b100.
  - Required: core_hold high for 4 cycles.
  - core_rst_n = 3'b011 for cycles 3–4.
  - pc_override_en one pulse with pc_override = 0x40.
  - wr_sel/rd_sel high for 4 cycles.
  - fault_count = 1, and NORMAL at N+10.
- Double fault: voter_state = 3'b011 in NORMAL.
  - Required: fatal = 1 and core_hold = 1 the next cycle, held for 20 cycles.
  - rst_in low then clears both to 0.
- Retry then success: fault on core B (3'b010) with voter_state = 3'b010 in replay cycle 2 of attempt 1.
  - Required: return to HOLD with faulty_core = 1.
  - The second replay is clean, giving fault_count = 1.
- Retry exhaustion: a mismatch during each of 3 replays.
  - Required: FATAL at the third failure, with fault_count unchanged.
- Reset mid-operation: rst_in low during RESET.
  - Required: immediately core_rst_n = 3'b111, core_hold = 0, ckpt_pc = 0, busy = 0.
- Saturation and checkpoint freeze:
  - Force 255 recoveries (CNT_W = 8), then one more. Required: fault_count stays 255.
  - A mismatch cycle with pc_voted = 0x99. Required: ckpt_pc does not update to 0x99.

Source files
------------

// File: rtl/tmr_pkg.sv
// Shared types and helpers for the TMR recovery sequencer.
// Holds the sequencer state encoding, core indices and fault-pattern helpers.
package tmr_pkg;

  typedef enum logic [2:0] {
    ST_NORMAL,
    ST_HOLD,
    ST_RESET,
    ST_REPLAY,
    ST_RESUME,
    ST_FATAL
  } tmr_state_e;

  localparam logic [1:0] CORE_A = 2'd0;
  localparam logic [1:0] CORE_B = 2'd1;
  localparam logic [1:0] CORE_C = 2'd2;

  localparam logic [2:0] VOTE_AGREE = 3'b000;

  localparam int TMR_TIMER_W = 16;

  // True when exactly one core disagrees with the majority.
  function automatic logic onehot3(input logic [2:0] vote);
    return (vote == 3'b001) || (vote == 3'b010) || (vote == 3'b100);
  endfunction

  function automatic logic [1:0] fault_index(input logic [2:0] vote);
    logic [1:0] idx;
    if (vote[0])      idx = CORE_A;
    else if (vote[1]) idx = CORE_B;
    else              idx = CORE_C;
    return idx;
  endfunction

endpackage

// File: rtl/tmr_recovery_sequencer.sv
// Recovery sequencer for the TMR core: checkpoints the voted PC and walks a faulty
// core through hold, reset, checkpoint replay and resume, or latches FATAL.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// NORMAL    | all cores running, checkpoint follows agreed PC
// HOLD      | all cores stalled before the faulty-core reset
// RESET     | all cores stalled, faulty core held in reset
// REPLAY    | cores run from checkpoint, stores go to recovery register
// RESUME    | one-cycle handback to memory, recovery counted
// FATAL     | unrecoverable, only rst_in leaves
module tmr_recovery_sequencer
  import tmr_pkg::*;
#(
  parameter int HOLD_CYCLES   = 2,
  parameter int RST_CYCLES    = 2,
  parameter int REPLAY_CYCLES = 4,
  parameter int MAX_RETRY     = 3,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic [2:0]       voter_state,
  input  logic [31:0]      pc_voted,
  output logic             core_hold,
  output logic [2:0]       core_rst_n,
  output logic             pc_override_en,
  output logic [31:0]      pc_override,
  output logic             recovery_mode,
  output logic             wr_sel,
  output logic             rd_sel,
  output logic [1:0]       faulty_core,
  output logic [CNT_W-1:0] fault_count,
  output logic             fatal,
  output logic             busy
);

  localparam int RETRY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

  localparam logic [TMR_TIMER_W-1:0] HOLD_LD   = TMR_TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_TIMER_W-1:0] RST_LD    = TMR_TIMER_W'(RST_CYCLES - 1);
  localparam logic [TMR_TIMER_W-1:0] REPLAY_LD = TMR_TIMER_W'(REPLAY_CYCLES - 1);
  localparam logic [RETRY_W-1:0]     RETRY_LAST = RETRY_W'(MAX_RETRY - 1);

  tmr_state_e               state, state_nxt;
  logic [TMR_TIMER_W-1:0]   cnt, cnt_nxt;
  logic [RETRY_W-1:0]       retry, retry_nxt;
  logic [1:0]               fcore, fcore_nxt;
  logic [31:0]              ckpt_pc, ckpt_nxt;
  logic [CNT_W-1:0]         fcount, fcount_nxt;

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state   <= ST_NORMAL;
      cnt     <= '0;
      retry   <= '0;
      fcore   <= CORE_A;
      ckpt_pc <= '0;
      fcount  <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      retry   <= retry_nxt;
      fcore   <= fcore_nxt;
      ckpt_pc <= ckpt_nxt;
      fcount  <= fcount_nxt;
    end
  end

  // Every transition reloads cnt; within a timed state it counts down to zero.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = (cnt != '0) ? cnt - TMR_TIMER_W'(1) : cnt;
    retry_nxt  = retry;
    fcore_nxt  = fcore;
    ckpt_nxt   = ckpt_pc;
    fcount_nxt = fcount;
    case (state)
      ST_NORMAL: begin
        if (voter_state == VOTE_AGREE) begin
          ckpt_nxt = pc_voted;
        end else if (onehot3(voter_state)) begin
          fcore_nxt = fault_index(voter_state);
          retry_nxt = '0;
          state_nxt = ST_HOLD;
          cnt_nxt   = HOLD_LD;
        end else begin
          state_nxt = ST_FATAL;
          cnt_nxt   = '0;
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          state_nxt = ST_RESET;
          cnt_nxt   = RST_LD;
        end
      end
      ST_RESET: begin
        if (cnt == '0) begin
          state_nxt = ST_REPLAY;
          cnt_nxt   = REPLAY_LD;
        end
      end
      ST_REPLAY: begin
        if (voter_state != VOTE_AGREE) begin
          if (retry == RETRY_LAST) begin
            state_nxt = ST_FATAL;
            cnt_nxt   = '0;
          end else begin
            retry_nxt = retry + RETRY_W'(1);
            state_nxt = ST_HOLD;
            cnt_nxt   = HOLD_LD;
          end
        end else if (cnt == '0) begin
          state_nxt = ST_RESUME;
          cnt_nxt   = '0;
        end
      end
      ST_RESUME: begin
        state_nxt = ST_NORMAL;
        cnt_nxt   = '0;
        if (fcount != '1) fcount_nxt = fcount + CNT_W'(1);
      end
      ST_FATAL: begin
        state_nxt = ST_FATAL;
      end
      default: begin
        state_nxt = ST_FATAL;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    core_hold      = 1'b0;
    core_rst_n     = 3'b111;
    pc_override_en = 1'b0;
    recovery_mode  = 1'b0;
    wr_sel         = 1'b0;
    rd_sel         = 1'b0;
    fatal          = 1'b0;
    busy           = (state != ST_NORMAL);
    case (state)
      ST_HOLD: begin
        core_hold     = 1'b1;
        recovery_mode = 1'b1;
      end
      ST_RESET: begin
        core_hold     = 1'b1;
        recovery_mode = 1'b1;
        core_rst_n    = ~(3'b001 << fcore);
      end
      ST_REPLAY: begin
        recovery_mode  = 1'b1;
        wr_sel         = 1'b1;
        rd_sel         = 1'b1;
        pc_override_en = (cnt == REPLAY_LD);
      end
      ST_RESUME: begin
        recovery_mode = 1'b1;
      end
      ST_FATAL: begin
        core_hold = 1'b1;
        fatal     = 1'b1;
      end
      default: begin
        core_hold = 1'b0;
      end
    endcase
  end

  assign pc_override = ckpt_pc;
  assign faulty_core = fcore;
  assign fault_count = fcount;

endmodule

// File: tb/tb_tmr_recovery_sequencer.sv
// Self-checking bench for tmr_recovery_sequencer: vector table, directed corner
// sequences and a randomized run against a timeline-based reference model.
module tb_tmr_recovery_sequencer;

  localparam int H  = 2;
  localparam int R  = 2;
  localparam int P  = 4;
  localparam int MR = 3;
  localparam int T  = H + R + P + 1;
  localparam int CMAX = 255;

  logic        clk = 1'b0;
  logic        rst_in;
  logic [2:0]  voter_state;
  logic [31:0] pc_voted;
  logic        core_hold;
  logic [2:0]  core_rst_n;
  logic        pc_override_en;
  logic [31:0] pc_override;
  logic        recovery_mode;
  logic        wr_sel;
  logic        rd_sel;
  logic [1:0]  faulty_core;
  logic [7:0]  fault_count;
  logic        fatal;
  logic        busy;

  always #5 clk = ~clk;

  tmr_recovery_sequencer #(
    .HOLD_CYCLES(H), .RST_CYCLES(R), .REPLAY_CYCLES(P), .MAX_RETRY(MR), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_in(rst_in), .voter_state(voter_state), .pc_voted(pc_voted),
    .core_hold(core_hold), .core_rst_n(core_rst_n), .pc_override_en(pc_override_en),
    .pc_override(pc_override), .recovery_mode(recovery_mode), .wr_sel(wr_sel),
    .rd_sel(rd_sel), .faulty_core(faulty_core), .fault_count(fault_count),
    .fatal(fatal), .busy(busy)
  );

  int n_pass = 0;
  int n_tot  = 0;

  // Reference model: mode 0 = running, 1 = recovering, 2 = fatal.
  // While recovering, m_k is the cycle offset inside the current attempt.
  int          m_mode, m_k, m_retry, m_fcore, m_count;
  logic [31:0] m_ckpt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_mode = 0; m_k = 0; m_retry = 0; m_fcore = 0; m_count = 0; m_ckpt = '0;
  endtask

  task automatic model_step(input logic [2:0] vs, input logic [31:0] pc);
    if (m_mode == 0) begin
      if (vs == 3'b000) m_ckpt = pc;
      else if ($countones(vs) == 1) begin
        for (int i = 0; i < 3; i++) if (vs[i]) m_fcore = i;
        m_retry = 0; m_k = 0; m_mode = 1;
      end else m_mode = 2;
    end else if (m_mode == 1) begin
      if (m_k >= H + R && m_k < H + R + P && vs != 3'b000) begin
        if (m_retry == MR - 1) m_mode = 2;
        else begin m_retry++; m_k = 0; end
      end else if (m_k == T - 1) begin
        m_mode = 0;
        if (m_count < CMAX) m_count++;
      end else m_k++;
    end
  endtask

  task automatic model_cmp(input string tag);
    logic       rp, e_hold, e_en;
    logic [2:0] one, e_rst;
    rp     = (m_mode == 1) && (m_k >= H + R) && (m_k < H + R + P);
    e_hold = (m_mode == 2) || (m_mode == 1 && m_k < H + R);
    e_en   = (m_mode == 1) && (m_k == H + R);
    one    = 3'b001 << m_fcore;
    e_rst  = (m_mode == 1 && m_k >= H && m_k < H + R) ? ~one : 3'b111;
    chk({tag, ".hold"}, 32'(core_hold), 32'(e_hold));
    chk({tag, ".rst_n"}, 32'(core_rst_n), 32'(e_rst));
    chk({tag, ".ovr_en"}, 32'(pc_override_en), 32'(e_en));
    chk({tag, ".rec_mode"}, 32'(recovery_mode), 32'(m_mode == 1));
    chk({tag, ".wr_sel"}, 32'(wr_sel), 32'(rp));
    chk({tag, ".rd_sel"}, 32'(rd_sel), 32'(rp));
    chk({tag, ".fcore"}, 32'(faulty_core), 32'(m_fcore));
    chk({tag, ".count"}, 32'(fault_count), 32'(m_count));
    chk({tag, ".fatal"}, 32'(fatal), 32'(m_mode == 2));
    chk({tag, ".busy"}, 32'(busy), 32'(m_mode != 0));
    if (rp) chk({tag, ".ovr"}, pc_override, m_ckpt);
  endtask

  task automatic step(input logic [2:0] vs, input logic [31:0] pc, input string tag);
    voter_state = vs;
    pc_voted    = pc;
    @(posedge clk);
    model_step(vs, pc);
    #1;
    model_cmp(tag);
  endtask

  // Called one time unit after a rising edge; reset lands mid-cycle.
  task automatic do_reset(input string tag);
    #2;
    rst_in = 1'b0;
    voter_state = 3'b000;
    pc_voted = '0;
    model_reset();
    #1;
    chk({tag, ".rst_hold"}, 32'(core_hold), 32'd0);
    chk({tag, ".rst_rst_n"}, 32'(core_rst_n), 32'h7);
    chk({tag, ".rst_busy"}, 32'(busy), 32'd0);
    chk({tag, ".rst_fatal"}, 32'(fatal), 32'd0);
    chk({tag, ".rst_ovr"}, pc_override, 32'd0);
    chk({tag, ".rst_count"}, 32'(fault_count), 32'd0);
    chk({tag, ".rst_mode"}, 32'(recovery_mode | wr_sel | rd_sel | pc_override_en), 32'd0);
    #1;
    rst_in = 1'b1;
    @(posedge clk);
    model_step(3'b000, 32'd0);
    #1;
  endtask

  typedef struct {
    logic [2:0]  vs;
    logic [31:0] pc;
    logic        hold;
    logic [2:0]  rstn;
    logic        en;
    logic [31:0] ovr;
    logic        sel;
    logic        busy;
    logic [1:0]  fc;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{3'b000, 32'h40, 1'b0, 3'b111, 1'b0, 32'h0,  1'b0, 1'b0, 2'd0, 8'd0};
    tbl[1]  = '{3'b100, 32'h99, 1'b1, 3'b111, 1'b0, 32'h0,  1'b0, 1'b1, 2'd2, 8'd0};
    tbl[2]  = '{3'b011, 32'h98, 1'b1, 3'b111, 1'b0, 32'h0,  1'b0, 1'b1, 2'd2, 8'd0};
    tbl[3]  = '{3'b111, 32'h97, 1'b1, 3'b011, 1'b0, 32'h0,  1'b0, 1'b1, 2'd2, 8'd0};
    tbl[4]  = '{3'b000, 32'h96, 1'b1, 3'b011, 1'b0, 32'h0,  1'b0, 1'b1, 2'd2, 8'd0};
    tbl[5]  = '{3'b000, 32'h95, 1'b0, 3'b111, 1'b1, 32'h40, 1'b1, 1'b1, 2'd2, 8'd0};
    tbl[6]  = '{3'b000, 32'h94, 1'b0, 3'b111, 1'b0, 32'h0,  1'b1, 1'b1, 2'd2, 8'd0};
    tbl[7]  = '{3'b000, 32'h93, 1'b0, 3'b111, 1'b0, 32'h0,  1'b1, 1'b1, 2'd2, 8'd0};
    tbl[8]  = '{3'b000, 32'h92, 1'b0, 3'b111, 1'b0, 32'h0,  1'b1, 1'b1, 2'd2, 8'd0};
    tbl[9]  = '{3'b000, 32'h91, 1'b0, 3'b111, 1'b0, 32'h0,  1'b0, 1'b1, 2'd2, 8'd0};
    tbl[10] = '{3'b001, 32'h55, 1'b0, 3'b111, 1'b0, 32'h0,  1'b0, 1'b0, 2'd2, 8'd1};
    tbl[11] = '{3'b000, 32'h60, 1'b0, 3'b111, 1'b0, 32'h0,  1'b0, 1'b0, 2'd2, 8'd1};

    rst_in = 1'b0;
    voter_state = 3'b000;
    pc_voted = '0;
    model_reset();
    #3;
    chk("reset.hold", 32'(core_hold), 32'd0);
    chk("reset.rst_n", 32'(core_rst_n), 32'h7);
    chk("reset.ovr", pc_override, 32'd0);
    chk("reset.busy_fatal", 32'(busy | fatal | recovery_mode | pc_override_en), 32'd0);
    chk("reset.sel", 32'({wr_sel, rd_sel}), 32'd0);
    chk("reset.fcore_count", 32'({faulty_core, fault_count}), 32'd0);
    #9;
    rst_in = 1'b1;
    @(posedge clk);
    model_step(3'b000, 32'd0);
    #1;

    // Single fault on core C, table driven
    for (int i = 0; i < 12; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      voter_state = tbl[i].vs;
      pc_voted    = tbl[i].pc;
      @(posedge clk);
      model_step(tbl[i].vs, tbl[i].pc);
      #1;
      chk({t, ".hold"}, 32'(core_hold), 32'(tbl[i].hold));
      chk({t, ".rst_n"}, 32'(core_rst_n), 32'(tbl[i].rstn));
      chk({t, ".ovr_en"}, 32'(pc_override_en), 32'(tbl[i].en));
      if (tbl[i].en) chk({t, ".ovr"}, pc_override, tbl[i].ovr);
      chk({t, ".wr_sel"}, 32'(wr_sel), 32'(tbl[i].sel));
      chk({t, ".rd_sel"}, 32'(rd_sel), 32'(tbl[i].sel));
      chk({t, ".busy"}, 32'(busy), 32'(tbl[i].busy));
      chk({t, ".rec_mode"}, 32'(recovery_mode), 32'(tbl[i].busy));
      chk({t, ".fcore"}, 32'(faulty_core), 32'(tbl[i].fc));
      chk({t, ".count"}, 32'(fault_count), 32'(tbl[i].cnt));
    end

    // Double fault goes FATAL and stays there until reset
    do_reset("dbl");
    step(3'b000, 32'h10, "dbl.pre");
    step(3'b011, 32'h20, "dbl.hit");
    chk("dbl.fatal", 32'(fatal), 32'd1);
    chk("dbl.hold", 32'(core_hold), 32'd1);
    for (int i = 0; i < 20; i++) begin
      step(3'($urandom_range(0, 7)), $urandom, "dbl.stay");
      chk("dbl.fatal_held", 32'({fatal, core_hold}), 32'h3);
    end
    do_reset("dbl.clear");

    // Retry then success on core B
    step(3'b000, 32'h100, "rty.pre");
    step(3'b010, 32'h104, "rty.fault");
    for (int i = 0; i < 5; i++) step(3'b000, 32'h108, "rty.a1");
    step(3'b010, 32'h10c, "rty.fail");
    chk("rty.back_hold", 32'({core_hold, wr_sel, busy}), 32'b101);
    chk("rty.fcore", 32'(faulty_core), 32'd1);
    for (int i = 0; i < T; i++) step(3'b000, 32'h110, "rty.a2");
    chk("rty.count", 32'(fault_count), 32'd1);
    chk("rty.normal", 32'(busy), 32'd0);

    // Retry exhaustion
    do_reset("exh");
    step(3'b000, 32'h200, "exh.pre");
    step(3'b001, 32'h204, "exh.fault");
    for (int a = 0; a < MR; a++) begin
      for (int i = 0; i < H + R; i++) step(3'b000, 32'h208, "exh.run");
      step(3'b101, 32'h20c, "exh.fail");
      if (a < MR - 1) chk("exh.retry_hold", 32'({core_hold, fatal}), 32'b10);
    end
    chk("exh.fatal", 32'(fatal), 32'd1);
    chk("exh.count", 32'(fault_count), 32'd0);

    // Reset in the middle of the faulty-core reset
    do_reset("mid.pre");
    step(3'b000, 32'h40, "mid.ckpt");
    step(3'b010, 32'h44, "mid.fault");
    for (int i = 0; i < H; i++) step(3'b000, 32'h48, "mid.hold");
    chk("mid.in_reset", 32'(core_rst_n), 32'b101);
    do_reset("mid");

    // Saturation of fault_count
    for (int n = 0; n < CMAX + 1; n++) begin
      step(3'b000, 32'(n), "sat.clean");
      step(3'b001 << (n % 3), 32'h99, "sat.fault");
      for (int i = 0; i < T; i++) step(3'b000, 32'h0, "sat.rec");
    end
    chk("sat.count", 32'(fault_count), 32'd255);

    // Randomized run against the model
    do_reset("rnd.pre");
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [2:0] vs;
      r = $urandom_range(0, 99);
      if (r < 80) vs = 3'b000;
      else if (r < 97) vs = 3'b001 << $urandom_range(0, 2);
      else vs = 3'($urandom_range(1, 7));
      if ((m_mode == 2 && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0)
        do_reset("rnd.rst");
      else
        step(vs, $urandom, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
